pcie_rx_stream_arbiter: RTL

//  N-channel successor to the fixed EDS/FBC/PMT Aurora RX path. Selects one session

---
 rtl/pcie_rx_stream_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pcie_rx_stream_arbiter.sv
// pcie_rx_stream_arbiter
//   Selects one session channel out of NUM_CH, drains its (non-FWFT) FIFO and streams
//   the words onto a single aurora_rxen/aurora_rxdata bus toward the PCIe DMA writer.
//   Sessions end with an orderly drain of in-flight reads followed by a done pulse; a new
//   start edge on any channel aborts the running session and flushes everything in flight.
//
// Ports
//   aurora_log_clk     clock, single domain
//   aurora_rst_n       asynchronous active-low reset
//   ch_start_i         per-channel session-start level
//   ch_end_i           per-channel session-end level
//   ch_almost_empty_i  per-channel FIFO almost_empty
//   ch_dout_i          FIFO data, channel k at [k*DATA_W +: DATA_W]
//   ch_rd_en_o         per-channel FIFO read enable (registered)
//   ch_fifo_rst_o      per-channel 1-cycle FIFO reset pulse on a start edge
//   aurora_rxen        output beat valid (registered)
//   aurora_rxdata      output beat data (registered, holds when not valid)
//   active_ch_o        selected channel, meaningful while busy_o is high
//   busy_o             high while streaming or draining
//   sess_beats_o       saturating beat count of the current/last session
//   sess_done_o        1-cycle pulse on normal session completion

module pcie_rx_stream_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 32,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     aurora_log_clk,
    input  logic                     aurora_rst_n,
    input  logic [NUM_CH-1:0]        ch_start_i,
    input  logic [NUM_CH-1:0]        ch_end_i,
    input  logic [NUM_CH-1:0]        ch_almost_empty_i,
    input  logic [NUM_CH*DATA_W-1:0] ch_dout_i,
    output logic [NUM_CH-1:0]        ch_rd_en_o,
    output logic [NUM_CH-1:0]        ch_fifo_rst_o,
    output logic                     aurora_rxen,
    output logic [DATA_W-1:0]        aurora_rxdata,
    output logic [CH_W-1:0]          active_ch_o,
    output logic                     busy_o,
    output logic [CNT_W-1:0]         sess_beats_o,
    output logic                     sess_done_o
);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   start_q;
    logic                armed_q;
    logic [NUM_CH-1:0]   rd_en_q, rd_en_d;
    logic [NUM_CH-1:0]   fifo_rst_q;
    logic                rxen_q;
    logic [DATA_W-1:0]   rxdata_q;
    logic [CH_W-1:0]     active_q, active_d;
    logic [CNT_W-1:0]    beats_q;
    logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;

    logic [NUM_CH-1:0]   start_edge;
    logic [NUM_CH-1:0]   cand;
    logic                pick_valid;
    logic [CH_W-1:0]     pick_idx;
    logic                abort;
    logic                vld;
    logic                beats_clr;
    logic [DATA_W-1:0]   sel_data;

    // The first cycle after reset only captures the start levels, so a level that was
    // already high across reset is not mistaken for a fresh edge.
    assign start_edge = armed_q ? (ch_start_i & ~start_q) : '0;
    assign cand       = ch_start_i & ~ch_end_i;
    assign abort      = (state_q != StIdle) && (|start_edge);
    assign vld        = vld_pipe_q[RD_LAT-1];

    // Lowest-index eligible channel.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
            if (cand[k]) begin
                pick_valid = 1'b1;
                pick_idx   = CH_W'(k);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (active_q == CH_W'(k)) begin
                sel_data = ch_dout_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_en_d   = '0;
        active_d  = active_q;
        beats_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!(|start_edge) && pick_valid) begin
                    state_d   = StStream;
                    active_d  = pick_idx;
                    beats_clr = 1'b1;
                end
            end
            StStream: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (ch_end_i[active_q]) begin
                    state_d = StDrain;
                end else begin
                    // Reads only while the FIFO is not almost empty: never underflows.
                    rd_en_d[active_q] = ~ch_almost_empty_i[active_q];
                end
            end
            StDrain: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (vld_pipe_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Stage 0 is the registered rd_en; the last stage lines up with valid FIFO data.
    always_comb begin
        vld_pipe_d    = '0;
        vld_pipe_d[0] = |rd_en_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
        end
        if (abort) begin
            vld_pipe_d = '0;
        end
    end

    always_ff @(posedge aurora_log_clk or negedge aurora_rst_n) begin
        if (!aurora_rst_n) begin
            state_q    <= StIdle;
            start_q    <= '0;
            armed_q    <= 1'b0;
            rd_en_q    <= '0;
            fifo_rst_q <= '0;
            rxen_q     <= 1'b0;
            rxdata_q   <= '0;
            active_q   <= '0;
            beats_q    <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= ch_start_i;
            armed_q    <= 1'b1;
            rd_en_q    <= rd_en_d;
            fifo_rst_q <= start_edge;
            active_q   <= active_d;
            vld_pipe_q <= vld_pipe_d;
            rxen_q     <= vld && !abort;
            if (vld && !abort) begin
                rxdata_q <= sel_data;
            end
            if (beats_clr) begin
                beats_q <= '0;
            end else if (vld && !abort && (beats_q != {CNT_W{1'b1}})) begin
                beats_q <= beats_q + CNT_W'(1);
            end
        end
    end

    assign ch_rd_en_o    = rd_en_q;
    assign ch_fifo_rst_o = fifo_rst_q;
    assign aurora_rxen   = rxen_q;
    assign aurora_rxdata = rxdata_q;
    assign active_ch_o   = active_q;
    assign busy_o        = (state_q == StStream) || (state_q == StDrain);
    assign sess_beats_o  = beats_q;
    assign sess_done_o   = (state_q == StDone);

endmodule
